bist_scheduler: RTL
===================

# bist_scheduler

Sequences built-in self-test across the router's link ports. One request runs each port's BIST sender/checker pair in turn, from port 0 upward. The block holds every sender in reset, releases one port at a time, waits for that sender to finish its pattern burst, and samples the checker's error flag. It sits beside the per-port BIST senders and leaves each tested port released, so that port's sender stays in pass-through (mission) mode.

## Interface
Parameters:
- NUM_PORTS, 5, number of link ports under test (≥1)
- SETTLE_CYCLES, 4, cycles for the initial all-port reset hold and for the post-ready drain (≥1)
- TIMEOUT_CYCLES, 1100, maximum RUN cycles before a port is declared timed out (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request; accepted only in IDLE or DONE
- port_ready  in  NUM_PORTS  per-port sender finished (level)
- port_error  in  NUM_PORTS  per-port sticky checker mismatch flag (level)
- port_reset  out  NUM_PORTS  per-port sender/checker reset, active-high
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- cur_port  out  $clog2(NUM_PORTS) (min 1)  index of the port being tested
- pass_mask  out  NUM_PORTS  bit i set = port i passed in the last run
- timeout_mask  out  NUM_PORTS  bit i set = port i timed out in the last run

## Operation
- States: IDLE, HOLD, RUN, DRAIN, CHECK, DONE.
- Reset values:
  - state = IDLE.
  - port_reset = all ones.
  - busy, done, cur_port, pass_mask and timeout_mask = 0.
- IDLE/DONE, start=1:
  - go to HOLD.
  - set port_reset to all ones.
  - clear pass_mask, timeout_mask and cur_port.
  - load the counter with SETTLE_CYCLES.
- HOLD: decrement the counter each cycle. At 0, go to RUN, clear port_reset[cur_port] and load the counter with TIMEOUT_CYCLES.
- RUN:
  - port_ready[cur_port]=1: go to DRAIN and load the counter with SETTLE_CYCLES.
  - Otherwise decrement the counter. At 0, set timeout_mask[cur_port], set port_reset[cur_port] back to 1 (faulty link isolated) and go to CHECK.
  - If ready and the counter reaching 0 occur in the same cycle, ready wins.
- DRAIN: decrement the counter. At 0, go to CHECK. The drain covers checker pipeline latency.
- CHECK (one cycle):
  - pass_mask[cur_port] <= ~port_error[cur_port] & ~timeout_mask[cur_port].
  - A failed (non-timeout) port stays released.
  - If cur_port == NUM_PORTS-1, go to DONE. Otherwise increment cur_port and go to RUN with the counter loaded to TIMEOUT_CYCLES.
  - The HOLD phase is not repeated between ports.
- DONE: results held stable. port_reset is unchanged until the next start.
- Ignored inputs:
  - start while busy.
  - port_ready/port_error of ports other than cur_port.
- Counter width: $clog2(max(SETTLE_CYCLES, TIMEOUT_CYCLES)+1). The counter is loaded, never wraps.
- Asynchronous reset mid-run aborts immediately to the reset values. All senders are re-held in reset.

## Timing
- start sampled at edge N: busy=1 and port_reset=all ones from N+1. Port 0 released at N+1+SETTLE_CYCLES.
- port_ready[i] first high at edge M: CHECK at M+SETTLE_CYCLES, pass_mask[i] visible after M+SETTLE_CYCLES+1.
- Next port released the cycle after its predecessor's CHECK.
- done rises the cycle after the last CHECK. busy and done are never high together.
- All outputs are registered.

## Configuration
- BIST_SCHED_TIMEOUT_EN:
  - Defined: RUN watchdog active as described.
  - Undefined: no timeout. RUN waits indefinitely for port_ready, timeout_mask is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan
- NUM_PORTS=5, SETTLE_CYCLES=4, each port_ready rising 1000 cycles after its release, port_error=0 -> ports released in order 0..4, done high, pass_mask=5'b11111, timeout_mask=0, port_reset=0.
- Same run with port_error[2]=1 -> pass_mask=5'b11011, port_reset[2]=0 (still released), other ports tested normally.
- Timeout build, port_ready[3] never asserted, TIMEOUT_CYCLES=1100 -> port 3 in RUN exactly 1100 cycles, timeout_mask=5'b01000, pass_mask=5'b10111, port_reset=5'b01000.
- start pulsed during RUN of port 1 -> ignored, run completes unchanged. start in DONE -> masks cleared, port_reset all ones next cycle, new run.
- Asynchronous reset asserted during DRAIN of port 2 -> same cycle port_reset=all ones, busy=0, done=0, masks=0, state IDLE.
- port_ready[cur_port] and the timeout expiry on the same edge -> port treated as ready, timeout bit clear, pass_mask bit set when port_error=0.

Source files
------------

// File: rtl/bist_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : bist_scheduler_if
// Brief    : Control/status bundle between the BIST scheduler and the
//            per-port BIST sender/checker pairs. The slave modport is the
//            scheduler's view; the master modport is the requester/port side.
// Revision : 1.0 - initial release
// ============================================================================
interface bist_scheduler_if #(
    parameter int NUM_PORTS = 5
) ();
    localparam int CUR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                 start;
    logic [NUM_PORTS-1:0] port_ready;
    logic [NUM_PORTS-1:0] port_error;
    logic [NUM_PORTS-1:0] port_reset;
    logic                 busy;
    logic                 done;
    logic [CUR_W-1:0]     cur_port;
    logic [NUM_PORTS-1:0] pass_mask;
    logic [NUM_PORTS-1:0] timeout_mask;

    modport master (
        output start, port_ready, port_error,
        input  port_reset, busy, done, cur_port, pass_mask, timeout_mask
    );

    modport slave (
        input  start, port_ready, port_error,
        output port_reset, busy, done, cur_port, pass_mask, timeout_mask
    );
endinterface
`default_nettype wire

// File: rtl/bist_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bist_scheduler
// Brief    : Runs each link port's BIST sender/checker pair in turn, port 0
//            upward. All senders are held in reset for SETTLE_CYCLES, then
//            one port at a time is released, its burst completion awaited,
//            the checker pipeline drained, and its error flag sampled.
//            Tested ports are left released (mission mode).
//            Optional macro BIST_SCHED_TIMEOUT_EN enables the RUN watchdog;
//            without it RUN waits indefinitely and timeout_mask reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module bist_scheduler #(
    parameter int NUM_PORTS      = 5,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1100
) (
    input  wire logic       clk,
    input  wire logic       reset,
    bist_scheduler_if.slave sched_if
);
    localparam int CUR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CUR_W-1:0] LAST_PORT  = CUR_W'(NUM_PORTS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CUR_W-1:0]     cur_port_q;
    logic [NUM_PORTS-1:0] port_reset_q;
    logic [NUM_PORTS-1:0] pass_mask_q;
    logic                 busy_q;
    logic                 done_q;
`ifdef BIST_SCHED_TIMEOUT_EN
    logic [NUM_PORTS-1:0] timeout_mask_q;
`endif

    logic             ready_cur;
    logic             error_cur;
    logic [CUR_W-1:0] next_port;

    // Only the port under test is observed; other ports' flags are ignored.
    assign ready_cur = sched_if.port_ready[cur_port_q];
    assign error_cur = sched_if.port_error[cur_port_q];
    assign next_port = cur_port_q + CUR_W'(1);

    // Sequencer: state, counter and all registered outputs in one process.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            cur_port_q     <= '0;
            port_reset_q   <= '1;
            pass_mask_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef BIST_SCHED_TIMEOUT_EN
            timeout_mask_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (sched_if.start) begin
                        state_q        <= S_HOLD;
                        port_reset_q   <= '1;
                        pass_mask_q    <= '0;
                        cur_port_q     <= '0;
                        cnt_q          <= SETTLE_LD;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
`ifdef BIST_SCHED_TIMEOUT_EN
                        timeout_mask_q <= '0;
`endif
                    end
                end

                S_HOLD: begin
                    // Hold runs SETTLE_CYCLES+1 cycles so port 0 leaves reset
                    // one cycle after the count has fully expired.
                    if (cnt_q == '0) begin
                        state_q                  <= S_RUN;
                        port_reset_q[cur_port_q] <= 1'b0;
                        cnt_q                    <= TIMEOUT_LD;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                S_RUN: begin
                    // Ready has priority over a simultaneous watchdog expiry.
                    if (ready_cur) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= SETTLE_LD;
                    end
`ifdef BIST_SCHED_TIMEOUT_EN
                    else if (cnt_q == CNT_ONE) begin
                        // Port spent exactly TIMEOUT_CYCLES in RUN: isolate it.
                        timeout_mask_q[cur_port_q] <= 1'b1;
                        port_reset_q[cur_port_q]   <= 1'b1;
                        cnt_q                      <= '0;
                        state_q                    <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
`endif
                end

                S_DRAIN: begin
                    // Gives the checker pipeline SETTLE_CYCLES to flush.
                    if (cnt_q == CNT_ONE) begin
                        state_q <= S_CHECK;
                    end
                    cnt_q <= cnt_q - CNT_ONE;
                end

                S_CHECK: begin
`ifdef BIST_SCHED_TIMEOUT_EN
                    pass_mask_q[cur_port_q] <= ~error_cur & ~timeout_mask_q[cur_port_q];
`else
                    pass_mask_q[cur_port_q] <= ~error_cur;
`endif
                    if (cur_port_q == LAST_PORT) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        // Next port goes straight to RUN; no second hold.
                        cur_port_q              <= next_port;
                        port_reset_q[next_port] <= 1'b0;
                        cnt_q                   <= TIMEOUT_LD;
                        state_q                 <= S_RUN;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sched_if.port_reset   = port_reset_q;
    assign sched_if.busy         = busy_q;
    assign sched_if.done         = done_q;
    assign sched_if.cur_port     = cur_port_q;
    assign sched_if.pass_mask    = pass_mask_q;
`ifdef BIST_SCHED_TIMEOUT_EN
    assign sched_if.timeout_mask = timeout_mask_q;
`else
    assign sched_if.timeout_mask = '0;
`endif

endmodule
`default_nettype wire
